// File: rtl/decode_ctrl_pkg.sv
// Shared decode-stage definitions: opcodes, FSM state encoding, NOP and operand-usage helpers.
package decode_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    function automatic logic opc_legal(input logic [6:0] opc);
        return (opc == OPC_LOAD)   || (opc == OPC_STORE) || (opc == OPC_JAL)   ||
               (opc == OPC_JALR)   || (opc == OPC_BRANCH) || (opc == OPC_LUI)  ||
               (opc == OPC_AUIPC)  || (opc == OPC_OPIMM) || (opc == OPC_OP);
    endfunction

    // Illegal opcodes read no registers, so they never cause a bubble.
    function automatic logic rs1_used(input logic [6:0] opc);
        return (opc == OPC_LOAD)   || (opc == OPC_STORE) || (opc == OPC_JALR) ||
               (opc == OPC_BRANCH) || (opc == OPC_OPIMM) || (opc == OPC_OP);
    endfunction

    function automatic logic rs2_used(input logic [6:0] opc);
        return (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_OP);
    endfunction

endpackage

// File: rtl/decode_ctrl_hazard.sv
// id_hazard_check: combinational load-use detector between the issuing ID beat
// and the incoming fetch beat.
module id_hazard_check
    import decode_ctrl_pkg::*;
(
    input  logic [31:0] i_out_instr,
    input  logic [31:0] i_in_instr,
    input  logic        i_issue_fire,
    output logic        o_hazard
);

    logic [4:0] w_out_rd;
    logic [4:0] w_in_rs1;
    logic [4:0] w_in_rs2;
    logic [6:0] w_in_opc;
    logic       w_out_is_load;
    logic       w_unused;

    assign w_out_rd      = i_out_instr[11:7];
    assign w_in_rs1      = i_in_instr[19:15];
    assign w_in_rs2      = i_in_instr[24:20];
    assign w_in_opc      = i_in_instr[6:0];
    assign w_out_is_load = (i_out_instr[6:0] == OPC_LOAD) && (w_out_rd != 5'd0);
    assign w_unused      = ^{i_out_instr[31:12], i_in_instr[31:25], i_in_instr[11:7]};

    assign o_hazard = i_issue_fire && w_out_is_load &&
                      (((w_out_rd == w_in_rs1) && rs1_used(w_in_opc)) ||
                       ((w_out_rd == w_in_rs2) && rs2_used(w_in_opc)));

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: ID pipeline register, valid/ready handshake, load-use bubbles, flush.
// Build option DECODE_ILLEGAL_TRAP_EN enables opcode legality checking.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CYCLES    = 1,
    parameter logic        SIGNEXT_DEFAULT = 1'b1,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_valid,
    input  logic [31:0] i_if_instr,
    input  logic [31:0] i_if_pc,
    output logic        o_if_ready,
    output logic        o_id_valid,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc,
    output logic [6:0]  o_id_opcode,
    output logic        o_id_signext,
    output logic        o_id_illegal,
    input  logic        i_ex_ready,
    input  logic        i_flush
);

    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [6:0]  r_id_opcode;
    logic        r_id_signext;
    logic        r_id_illegal;

    logic w_issue_fire;
    logic w_capture;
    logic w_hazard;
    logic w_illegal;
    logic w_signext;

    assign w_issue_fire = (r_state == S_FULL) && i_ex_ready;
    assign o_if_ready   = i_flush || (r_state == S_EMPTY) || w_issue_fire;
    // A beat handshaken during flush is accepted on the wire but dropped here.
    assign w_capture    = i_if_valid && o_if_ready && !i_flush;

    id_hazard_check u_hazard (
        .i_out_instr  (r_id_instr),
        .i_in_instr   (i_if_instr),
        .i_issue_fire (w_issue_fire),
        .o_hazard     (w_hazard)
    );

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign w_illegal = !opc_legal(i_if_instr[6:0]);
`else
    assign w_illegal = 1'b0;
`endif
    assign w_signext = w_illegal ? 1'b0 : SIGNEXT_DEFAULT;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_EMPTY;
            r_cnt        <= 3'd0;
            r_id_valid   <= 1'b0;
            r_id_instr   <= NOP_INSTR;
            r_id_pc      <= RESET_PC;
            r_id_opcode  <= NOP_INSTR[6:0];
            r_id_signext <= SIGNEXT_DEFAULT;
            r_id_illegal <= 1'b0;
        end else if (i_flush) begin
            r_state    <= S_EMPTY;
            r_cnt      <= 3'd0;
            r_id_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_id_instr   <= i_if_instr;
                r_id_pc      <= i_if_pc;
                r_id_opcode  <= i_if_instr[6:0];
                r_id_signext <= w_signext;
                r_id_illegal <= w_illegal;
            end
            case (r_state)
                S_EMPTY, S_FULL: begin
                    if (w_capture && w_hazard) begin
                        r_state    <= S_STALL;
                        r_cnt      <= STALL_LOAD;
                        r_id_valid <= 1'b0;
                    end else if (w_capture) begin
                        r_state    <= S_FULL;
                        r_id_valid <= 1'b1;
                    end else if (w_issue_fire) begin
                        r_state    <= S_EMPTY;
                        r_id_valid <= 1'b0;
                    end
                end
                S_STALL: begin
                    if (r_cnt <= 3'd1) begin
                        r_state    <= S_FULL;
                        r_cnt      <= 3'd0;
                        r_id_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_cnt      <= 3'd0;
                    r_id_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_id_valid   = r_id_valid;
    assign o_id_instr   = r_id_instr;
    assign o_id_pc      = r_id_pc;
    assign o_id_opcode  = r_id_opcode;
    assign o_id_signext = r_id_signext;
    assign o_id_illegal = r_id_illegal;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: two instances (1-cycle and 3-cycle stall) on shared stimulus.
module tb_decode_ctrl;
    import decode_ctrl_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, if_valid, ex_ready, flush;
    logic [31:0] if_instr, if_pc;

    logic        a_if_ready, a_valid, a_signext, a_illegal;
    logic [31:0] a_instr, a_pc;
    logic [6:0]  a_opcode;
    logic        b_if_ready, b_valid, b_signext, b_illegal;
    logic [31:0] b_instr, b_pc;
    logic [6:0]  b_opcode;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_ctrl #(.STALL_CYCLES(1), .SIGNEXT_DEFAULT(1'b1), .RESET_PC(RPC)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .i_if_instr(if_instr),
        .i_if_pc(if_pc), .o_if_ready(a_if_ready), .o_id_valid(a_valid),
        .o_id_instr(a_instr), .o_id_pc(a_pc), .o_id_opcode(a_opcode),
        .o_id_signext(a_signext), .o_id_illegal(a_illegal),
        .i_ex_ready(ex_ready), .i_flush(flush)
    );

    decode_ctrl #(.STALL_CYCLES(3), .SIGNEXT_DEFAULT(1'b1), .RESET_PC(RPC)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .i_if_instr(if_instr),
        .i_if_pc(if_pc), .o_if_ready(b_if_ready), .o_id_valid(b_valid),
        .o_id_instr(b_instr), .o_id_pc(b_pc), .o_id_opcode(b_opcode),
        .o_id_signext(b_signext), .o_id_illegal(b_illegal),
        .i_ex_ready(ex_ready), .i_flush(flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        beat(1'b0, 32'h0, 32'h0);
        step(); step();
        rst = 1'b0;
        chk("rst_valid",   a_valid,   0);
        chk("rst_instr",   a_instr,   32'h0000_0013);
        chk("rst_opcode",  a_opcode,  7'b0010011);
        chk("rst_pc",      a_pc,      RPC);
        chk("rst_signext", a_signext, 1);
        chk("rst_illegal", a_illegal, 0);
        chk("rst_ready",   a_if_ready, 1);

        // Back-to-back stream
        beat(1'b1, 32'h0050_0093, 32'h10);
        step();
        chk("s0_valid",   a_valid,   1);
        chk("s0_instr",   a_instr,   32'h0050_0093);
        chk("s0_pc",      a_pc,      32'h10);
        chk("s0_opcode",  a_opcode,  7'b0010011);
        chk("s0_signext", a_signext, 1);
        beat(1'b1, 32'h0010_8113, 32'h14);
        #1 chk("s1_ready", a_if_ready, 1);
        step();
        chk("s1_valid", a_valid, 1);
        chk("s1_instr", a_instr, 32'h0010_8113);
        chk("s1_pc",    a_pc,    32'h14);

        // Backpressure
        beat(1'b1, 32'h0020_8193, 32'h18);
        ex_ready = 1'b0;
        #1 chk("bp_ready", a_if_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", a_valid, 1);
            chk("bp_instr", a_instr, 32'h0010_8113);
            chk("bp_ready_hold", a_if_ready, 0);
        end
        ex_ready = 1'b1;
        #1 chk("bp_release_ready", a_if_ready, 1);
        step();
        chk("bp_swap_instr", a_instr, 32'h0020_8193);
        chk("bp_swap_valid", a_valid, 1);

        // Load-use, one bubble
        beat(1'b1, 32'h0000_A183, 32'h1C);
        step();
        chk("lu_lw_instr", a_instr, 32'h0000_A183);
        beat(1'b1, 32'h0031_8233, 32'h20);
        step();
        beat(1'b0, 32'h0, 32'h0);
        chk("lu_bubble_valid", a_valid, 0);
        chk("lu_bubble_instr", a_instr, 32'h0031_8233);
        #1 chk("lu_bubble_ready", a_if_ready, 0);
        step();
        chk("lu_add_valid", a_valid, 1);
        chk("lu_add_instr", a_instr, 32'h0031_8233);
        step();
        chk("lu_drain_valid", a_valid, 0);

        // Same pair shape with rd=x0: no bubble
        beat(1'b1, 32'h0000_A003, 32'h24);
        step();
        beat(1'b1, 32'h0000_0233, 32'h28);
        step();
        chk("x0_valid", a_valid, 1);
        chk("x0_instr", a_instr, 32'h0000_0233);

        // Flush in S_FULL drops the presented beat
        flush = 1'b1;
        beat(1'b1, 32'h0070_0393, 32'h40);
        #1 chk("fl_ready", a_if_ready, 1);
        step();
        flush = 1'b0;
        beat(1'b0, 32'h0, 32'h0);
        chk("fl_valid", a_valid, 0);
        step();
        chk("fl_valid2", a_valid, 0);
        chk("fl_instr", a_instr, 32'h0000_0233);

        // Flush in the second of three stall cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst3_valid", b_valid, 0);
        chk("rst3_pc",    b_pc,    RPC);
        beat(1'b1, 32'h0000_A183, 32'h50);
        step();
        beat(1'b1, 32'h0031_8233, 32'h54);
        step();
        beat(1'b0, 32'h0, 32'h0);
        chk("st_state1", u_dut3.r_state, S_STALL);
        chk("st_cnt1",   u_dut3.r_cnt,   3);
        chk("st_valid1", b_valid, 0);
        step();
        chk("st_cnt2",   u_dut3.r_cnt,   2);
        chk("st_valid2", b_valid, 0);
        flush = 1'b1;
        #1 chk("st_fl_ready", b_if_ready, 1);
        step();
        flush = 1'b0;
        chk("st_fl_state", u_dut3.r_state, S_EMPTY);
        chk("st_fl_cnt",   u_dut3.r_cnt,   0);
        chk("st_fl_valid", b_valid, 0);
        step();
        chk("st_fl_valid2", b_valid, 0);

        // Illegal opcode
        beat(1'b1, 32'h0000_007F, 32'h60);
        step();
        beat(1'b0, 32'h0, 32'h0);
        chk("il_valid",  a_valid,  1);
        chk("il_opcode", a_opcode, 7'h7F);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("il_illegal", a_illegal, 1);
        chk("il_signext", a_signext, 0);
`else
        chk("il_illegal", a_illegal, 0);
        chk("il_signext", a_signext, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
